// File: rtl/dcache_data_read_responder_pkg.sv
`default_nettype none
// ============================================================================
// Package : dcache_data_pkg
// Brief   : Shared widths and record types for the dcache data-read responder.
// Rev     : 1.0  initial release
// ============================================================================
package dcache_data_pkg;

    localparam int NWAYS  = 8;
    localparam int ADDR_W = 12;
    localparam int DATA_W = 64;
    localparam int TAG_W  = 2;

    // Request metadata carried alongside the SRAM read latency
    typedef struct packed {
        logic [TAG_W-1:0]            tag;
        logic [1:0][NWAYS-1:0]       way_en;
        logic [1:0]                  valid;
    } dcache_rd_meta_t;

    // Completed response as stored in the response FIFO
    typedef struct packed {
        logic [TAG_W-1:0]            tag;
        logic [1:0][DATA_W-1:0]      data;
        logic [1:0]                  valid;
    } dcache_rd_resp_t;

endpackage
`default_nettype wire

// File: rtl/dcache_data_read_responder_if.sv
`default_nettype none
// ============================================================================
// Interface : dcache_data_read_responder_if
// Brief     : Request, SRAM and response signal bundle of the responder.
// Rev       : 1.0  initial release
// ============================================================================
interface dcache_data_read_responder_if;
    import dcache_data_pkg::*;

    logic                       io_req_valid;
    logic                       io_req_ready;
    logic [TAG_W-1:0]           io_req_bits_tag;
    logic [NWAYS-1:0]           io_req_bits_req_0_way_en;
    logic [NWAYS-1:0]           io_req_bits_req_1_way_en;
    logic [ADDR_W-1:0]          io_req_bits_req_0_addr;
    logic [ADDR_W-1:0]          io_req_bits_req_1_addr;
    logic                       io_req_bits_valid_0;
    logic                       io_req_bits_valid_1;
    logic                       io_sram_en;
    logic [ADDR_W-1:0]          io_sram_addr_0;
    logic [ADDR_W-1:0]          io_sram_addr_1;
    logic [NWAYS*DATA_W-1:0]    io_sram_rdata_0;
    logic [NWAYS*DATA_W-1:0]    io_sram_rdata_1;
    logic                       io_resp_valid;
    logic                       io_resp_ready;
    logic [TAG_W-1:0]           io_resp_bits_tag;
    logic [DATA_W-1:0]          io_resp_bits_data_0;
    logic [DATA_W-1:0]          io_resp_bits_data_1;
    logic                       io_resp_bits_valid_0;
    logic                       io_resp_bits_valid_1;

    // Requester / SRAM / consumer side
    modport master (
        output io_req_valid, io_req_bits_tag,
        output io_req_bits_req_0_way_en, io_req_bits_req_1_way_en,
        output io_req_bits_req_0_addr, io_req_bits_req_1_addr,
        output io_req_bits_valid_0, io_req_bits_valid_1,
        output io_sram_rdata_0, io_sram_rdata_1, io_resp_ready,
        input  io_req_ready, io_sram_en, io_sram_addr_0, io_sram_addr_1,
        input  io_resp_valid, io_resp_bits_tag, io_resp_bits_data_0,
        input  io_resp_bits_data_1, io_resp_bits_valid_0, io_resp_bits_valid_1
    );

    // Responder side
    modport slave (
        input  io_req_valid, io_req_bits_tag,
        input  io_req_bits_req_0_way_en, io_req_bits_req_1_way_en,
        input  io_req_bits_req_0_addr, io_req_bits_req_1_addr,
        input  io_req_bits_valid_0, io_req_bits_valid_1,
        input  io_sram_rdata_0, io_sram_rdata_1, io_resp_ready,
        output io_req_ready, io_sram_en, io_sram_addr_0, io_sram_addr_1,
        output io_resp_valid, io_resp_bits_tag, io_resp_bits_data_0,
        output io_resp_bits_data_1, io_resp_bits_valid_0, io_resp_bits_valid_1
    );
endinterface
`default_nettype wire

// File: rtl/dcache_data_read_responder_fifo.sv
`default_nettype none
// ============================================================================
// Module : dcache_resp_fifo
// Brief  : Synchronous response FIFO with occupancy count; head reads as zero
//          when empty so downstream outputs are clean after reset.
// Rev    : 1.0  initial release
// ============================================================================
module dcache_resp_fifo
    import dcache_data_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  wire logic            clk,
    input  wire logic            rst,
    input  wire logic            i_push,
    input  dcache_rd_resp_t      i_wdata,
    input  wire logic            i_pop,
    output dcache_rd_resp_t      o_rdata,
    output logic [CNT_W-1:0]     o_count,
    output logic                 o_full,
    output logic                 o_empty
);
    dcache_rd_resp_t    r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               w_do_pop;

    assign w_do_pop = i_pop && !o_empty;
    assign o_count  = r_count;
    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_empty  = (r_count == '0);
    assign o_rdata  = o_empty ? '0 : r_mem[r_rd_ptr];

    // Storage write; contents need no reset since the count qualifies them
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers wrap at DEPTH (which need not be a power of two) and the count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            end
            case ({i_push, w_do_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: rtl/dcache_data_read_responder.sv
`default_nettype none
// ============================================================================
// Module : dcache_data_read_responder
// Brief  : Drives the data-array SRAM for accepted two-lane reads, tracks them
//          through the fixed read latency, selects ways and queues responses.
//          Credit-based request backpressure guarantees no result is dropped.
// Rev    : 1.0  initial release
// ============================================================================
module dcache_data_read_responder
    import dcache_data_pkg::dcache_rd_meta_t;
    import dcache_data_pkg::dcache_rd_resp_t;
#(
    parameter int NWAYS        = dcache_data_pkg::NWAYS,
    parameter int ADDR_W       = dcache_data_pkg::ADDR_W,
    parameter int DATA_W       = dcache_data_pkg::DATA_W,
    parameter int TAG_W        = dcache_data_pkg::TAG_W,
    parameter int READ_LATENCY = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  wire logic                   clock,
    input  wire logic                   reset,
    dcache_data_read_responder_if.slave bus
);
    localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W  = FCNT_W + 1;

    logic                    w_accept;
    logic                    w_req_ready;
    logic                    w_exit;
    logic                    w_pop;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;
    logic [FCNT_W-1:0]       w_fifo_cnt;
    logic [CNT_W-1:0]        r_inflight_cnt;
    logic [TAG_W-1:0]        w_req_tag;
    logic [DATA_W-1:0]       w_sel_0;
    logic [DATA_W-1:0]       w_sel_1;
    dcache_rd_meta_t         w_req_meta;
    dcache_rd_meta_t         w_fin_meta;
    dcache_rd_meta_t         r_pipe_meta [READ_LATENCY];
    logic [READ_LATENCY-1:0] r_pipe_vld;
    dcache_rd_resp_t         w_push_resp;
    dcache_rd_resp_t         w_head;

    // Credit: everything in flight plus everything queued must fit in the FIFO
    assign w_req_ready = (r_inflight_cnt + {1'b0, w_fifo_cnt}) < CNT_W'(FIFO_DEPTH);
    assign w_accept    = bus.io_req_valid && w_req_ready && !reset;
    assign w_req_tag   = bus.io_req_bits_tag;
    assign w_exit      = r_pipe_vld[READ_LATENCY-1];
    assign w_fin_meta  = r_pipe_meta[READ_LATENCY-1];
    assign w_pop       = !w_fifo_empty && bus.io_resp_ready;

    assign bus.io_req_ready   = w_req_ready;
    assign bus.io_sram_en     = w_accept;
    assign bus.io_sram_addr_0 = (w_accept && bus.io_req_bits_valid_0) ? bus.io_req_bits_req_0_addr : {ADDR_W{1'b0}};
    assign bus.io_sram_addr_1 = (w_accept && bus.io_req_bits_valid_1) ? bus.io_req_bits_req_1_addr : {ADDR_W{1'b0}};

    // Metadata that must survive the SRAM latency
    always_comb begin
        w_req_meta           = '0;
        w_req_meta.tag       = w_req_tag;
        w_req_meta.way_en[0] = bus.io_req_bits_req_0_way_en;
        w_req_meta.way_en[1] = bus.io_req_bits_req_1_way_en;
        w_req_meta.valid     = {bus.io_req_bits_valid_1, bus.io_req_bits_valid_0};
    end

    // Latency pipeline occupancy; cleared by reset so in-flight returns are discarded
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pipe_vld <= '0;
        end else begin
            r_pipe_vld[0] <= w_accept;
            for (int s = 1; s < READ_LATENCY; s++) begin
                r_pipe_vld[s] <= r_pipe_vld[s-1];
            end
        end
    end

    // Latency pipeline metadata, qualified by r_pipe_vld
    always_ff @(posedge clock) begin
        r_pipe_meta[0] <= w_req_meta;
        for (int s = 1; s < READ_LATENCY; s++) begin
            r_pipe_meta[s] <= r_pipe_meta[s-1];
        end
    end

    // Outstanding SRAM reads not yet written into the FIFO
    always_ff @(posedge clock) begin
        if (reset) begin
            r_inflight_cnt <= '0;
        end else begin
            case ({w_accept, w_exit})
                2'b10:   r_inflight_cnt <= r_inflight_cnt + CNT_W'(1);
                2'b01:   r_inflight_cnt <= r_inflight_cnt - CNT_W'(1);
                default: r_inflight_cnt <= r_inflight_cnt;
            endcase
        end
    end

    // AND-OR way select; several enabled ways OR together, none gives zero
    always_comb begin
        w_sel_0 = '0;
        w_sel_1 = '0;
        for (int w = 0; w < NWAYS; w++) begin
            w_sel_0 = w_sel_0 | (bus.io_sram_rdata_0[w*DATA_W +: DATA_W] & {DATA_W{w_fin_meta.way_en[0][w]}});
            w_sel_1 = w_sel_1 | (bus.io_sram_rdata_1[w*DATA_W +: DATA_W] & {DATA_W{w_fin_meta.way_en[1][w]}});
        end
    end

    // Response record written when the final stage captures SRAM data
    always_comb begin
        w_push_resp         = '0;
        w_push_resp.tag     = w_fin_meta.tag;
        w_push_resp.valid   = w_fin_meta.valid;
        w_push_resp.data[0] = w_fin_meta.valid[0] ? w_sel_0 : '0;
        w_push_resp.data[1] = w_fin_meta.valid[1] ? w_sel_1 : '0;
    end

    dcache_resp_fifo #(
        .DEPTH   (FIFO_DEPTH)
    ) u_resp_fifo (
        .clk     (clock),
        .rst     (reset),
        .i_push  (w_exit),
        .i_wdata (w_push_resp),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_fifo_cnt),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty)
    );

    assign bus.io_resp_valid        = !w_fifo_empty;
    assign bus.io_resp_bits_tag     = w_head.tag;
    assign bus.io_resp_bits_data_0  = w_head.data[0];
    assign bus.io_resp_bits_data_1  = w_head.data[1];
    assign bus.io_resp_bits_valid_0 = w_head.valid[0];
    assign bus.io_resp_bits_valid_1 = w_head.valid[1];

    // Credit accounting must make a push into a full FIFO impossible
    a_fifo_no_overflow: assert property (@(posedge clock) disable iff (reset) !(w_exit && w_fifo_full));

endmodule
`default_nettype wire

// File: tb/tb_dcache_data_read_responder.sv
`default_nettype none
// ============================================================================
// Module : tb_dcache_data_read_responder
// Brief  : Self-checking bench: behavioural SRAM, queue-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dcache_data_read_responder;
    import dcache_data_pkg::*;

    localparam int READ_LATENCY = 2;
    localparam int FIFO_DEPTH   = 4;
    localparam int ROWS         = 1 << ADDR_W;
    localparam logic [DATA_W-1:0] GARBAGE = 64'hA5A5_5A5A_C3C3_3C3C;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    dcache_data_read_responder_if bus ();

    dcache_data_read_responder #(
        .NWAYS        (NWAYS),
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .TAG_W        (TAG_W),
        .READ_LATENCY (READ_LATENCY),
        .FIFO_DEPTH   (FIFO_DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Behavioural SRAM: data valid exactly READ_LATENCY cycles after the strobe
    logic [NWAYS*DATA_W-1:0] mem0 [ROWS];
    logic [NWAYS*DATA_W-1:0] mem1 [ROWS];
    logic [READ_LATENCY-1:0] sh_en = '0;
    logic [ADDR_W-1:0]       sh_a0 [READ_LATENCY];
    logic [ADDR_W-1:0]       sh_a1 [READ_LATENCY];

    always @(posedge clock) begin
        sh_en[0] <= bus.io_sram_en;
        sh_a0[0] <= bus.io_sram_addr_0;
        sh_a1[0] <= bus.io_sram_addr_1;
        for (int s = 1; s < READ_LATENCY; s++) begin
            sh_en[s] <= sh_en[s-1];
            sh_a0[s] <= sh_a0[s-1];
            sh_a1[s] <= sh_a1[s-1];
        end
    end

    assign bus.io_sram_rdata_0 = sh_en[READ_LATENCY-1] ? mem0[sh_a0[READ_LATENCY-1]] : {NWAYS{GARBAGE}};
    assign bus.io_sram_rdata_1 = sh_en[READ_LATENCY-1] ? mem1[sh_a1[READ_LATENCY-1]] : {NWAYS{GARBAGE}};

    // Scoreboard state
    dcache_rd_resp_t exp_q[$];
    dcache_rd_resp_t obs_q[$];
    int              acc_cyc_q[$];
    int              pop_cyc_q[$];
    int              cyc    = 0;
    int              errors = 0;
    int              checks = 0;

    logic            s_ready, s_en, s_rvalid;
    logic [ADDR_W-1:0] s_a0, s_a1;
    dcache_rd_resp_t s_head;

    // Expected response straight from the SRAM contents and the request
    function automatic dcache_rd_resp_t expect_resp(input logic [TAG_W-1:0] tag,
            input logic [NWAYS-1:0] we0, input logic [NWAYS-1:0] we1,
            input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
            input logic v0, input logic v1);
        dcache_rd_resp_t r;
        logic [NWAYS*DATA_W-1:0] row0, row1;
        row0 = mem0[a0];
        row1 = mem1[a1];
        r = '0;
        r.tag = tag;
        r.valid = {v1, v0};
        for (int w = 0; w < NWAYS; w++) begin
            if (v0 && we0[w]) r.data[0] = r.data[0] | row0[w*DATA_W +: DATA_W];
            if (v1 && we1[w]) r.data[1] = r.data[1] | row1[w*DATA_W +: DATA_W];
        end
        return r;
    endfunction

    // One clock: sample away from the edge, record accepts and pops, advance
    task automatic tick();
        #1;
        s_ready          = bus.io_req_ready;
        s_en             = bus.io_sram_en;
        s_a0             = bus.io_sram_addr_0;
        s_a1             = bus.io_sram_addr_1;
        s_rvalid         = bus.io_resp_valid;
        s_head           = '0;
        s_head.tag       = bus.io_resp_bits_tag;
        s_head.data[0]   = bus.io_resp_bits_data_0;
        s_head.data[1]   = bus.io_resp_bits_data_1;
        s_head.valid     = {bus.io_resp_bits_valid_1, bus.io_resp_bits_valid_0};
        if (reset) begin
            exp_q.delete();
            acc_cyc_q.delete();
        end else begin
            if (bus.io_req_valid && bus.io_req_ready) begin
                exp_q.push_back(expect_resp(bus.io_req_bits_tag, bus.io_req_bits_req_0_way_en,
                    bus.io_req_bits_req_1_way_en, bus.io_req_bits_req_0_addr,
                    bus.io_req_bits_req_1_addr, bus.io_req_bits_valid_0, bus.io_req_bits_valid_1));
                acc_cyc_q.push_back(cyc);
            end
            if (bus.io_resp_valid && bus.io_resp_ready) begin
                obs_q.push_back(s_head);
                pop_cyc_q.push_back(cyc);
            end
        end
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    task automatic drive_req(input logic v, input logic [TAG_W-1:0] tag,
            input logic [NWAYS-1:0] we0, input logic [NWAYS-1:0] we1,
            input logic [ADDR_W-1:0] a0, input logic [ADDR_W-1:0] a1,
            input logic l0, input logic l1);
        bus.io_req_valid             = v;
        bus.io_req_bits_tag          = tag;
        bus.io_req_bits_req_0_way_en = we0;
        bus.io_req_bits_req_1_way_en = we1;
        bus.io_req_bits_req_0_addr   = a0;
        bus.io_req_bits_req_1_addr   = a1;
        bus.io_req_bits_valid_0      = l0;
        bus.io_req_bits_valid_1      = l1;
    endtask

    task automatic random_req(input logic v);
        logic [NWAYS-1:0] we0, we1;
        we0 = ($urandom_range(0, 7) == 0) ? '0 : NWAYS'($urandom);
        we1 = ($urandom_range(0, 7) == 0) ? '0 : NWAYS'($urandom);
        drive_req(v, TAG_W'($urandom), we0, we1, ADDR_W'($urandom), ADDR_W'($urandom),
                  1'($urandom), 1'($urandom));
    endtask

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        acc_cyc_q.delete();
        pop_cyc_q.delete();
    endtask

    // Stop requesting, consume everything, and leave time for stray responses
    task automatic drain(output bit timed_out);
        bus.io_req_valid  = 1'b0;
        bus.io_resp_ready = 1'b1;
        timed_out = 1'b1;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (obs_q.size() >= exp_q.size() && i >= READ_LATENCY + FIFO_DEPTH + 2) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    task automatic test_reset();
        bit to;
        reset = 1'b1;
        bus.io_resp_ready = 1'b0;
        random_req(1'b1);
        tick();
        random_req(1'b1);
        tick();
        checks++;
        if (s_en !== 1'b0) begin errors++; $display("FAIL reset_no_accept sram_en=%b want 0", s_en); end
        reset = 1'b0;
        random_req(1'b0);
        tick();
        checks++;
        if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got=%b want 1", s_ready); end
        checks++;
        if (s_rvalid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid got=%b want 0", s_rvalid); end
        checks++;
        if (s_en !== 1'b0) begin errors++; $display("FAIL reset_sram_en got=%b want 0", s_en); end
        checks++;
        if (s_a0 !== '0 || s_a1 !== '0) begin errors++; $display("FAIL reset_sram_addr got=%h/%h want 0/0", s_a0, s_a1); end
        checks++;
        if (s_head !== '0) begin errors++; $display("FAIL reset_resp_bits got=%h want 0", s_head); end
        clear_queues();
        drain(to);
        checks++;
        if (obs_q.size() != 0 || to) begin errors++; $display("FAIL reset_no_resp got=%0d responses want 0 (timeout=%0d)", obs_q.size(), to); end
    endtask

    task automatic test_single();
        clear_queues();
        bus.io_resp_ready = 1'b1;
        drive_req(1'b1, 2'd2, 8'h04, 8'h0F, 12'h123, 12'h055, 1'b1, 1'b0);
        tick();
        checks++;
        if (s_en !== 1'b1) begin errors++; $display("FAIL single_sram_en got=%b want 1", s_en); end
        checks++;
        if (s_a0 !== 12'h123) begin errors++; $display("FAIL single_addr0 got=%h want 123", s_a0); end
        checks++;
        if (s_a1 !== 12'h000) begin errors++; $display("FAIL single_addr1 got=%h want 000", s_a1); end
        bus.io_req_valid = 1'b0;
        for (int i = 0; i < 10 && obs_q.size() == 0; i++) tick();
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL single_resp_count got=%0d want 1", obs_q.size());
        end else begin
            checks++;
            if (pop_cyc_q[0] - acc_cyc_q[0] != READ_LATENCY + 1)
                begin errors++; $display("FAIL single_latency got=%0d want %0d", pop_cyc_q[0] - acc_cyc_q[0], READ_LATENCY + 1); end
            checks++;
            if (obs_q[0].tag !== 2'd2) begin errors++; $display("FAIL single_tag got=%0d want 2", obs_q[0].tag); end
            checks++;
            if (obs_q[0].data[0] !== 64'hDEADBEEF) begin errors++; $display("FAIL single_data0 got=%h want deadbeef", obs_q[0].data[0]); end
            checks++;
            if (obs_q[0].data[1] !== '0 || obs_q[0].valid !== 2'b01)
                begin errors++; $display("FAIL single_lane1 got data1=%h valid=%b want 0/01", obs_q[0].data[1], obs_q[0].valid); end
        end
    endtask

    task automatic test_stream();
        bit to;
        clear_queues();
        bus.io_resp_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            random_req(1'b1);
            tick();
            checks++;
            if (s_ready !== 1'b1) begin errors++; $display("FAIL stream_ready[%0d] got=%b want 1", i, s_ready); end
        end
        drain(to);
        checks++;
        if (to || obs_q.size() != 16 || exp_q.size() != 16)
            begin errors++; $display("FAIL stream_count got=%0d exp=%0d want 16 (timeout=%0d)", obs_q.size(), exp_q.size(), to); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL stream_resp[%0d] got=%h want %h", i, obs_q[i], exp_q[i]); end
            checks++;
            if (pop_cyc_q[i] != acc_cyc_q[i] + READ_LATENCY + 1)
                begin errors++; $display("FAIL stream_timing[%0d] got=%0d want %0d", i, pop_cyc_q[i], acc_cyc_q[i] + READ_LATENCY + 1); end
        end
    endtask

    task automatic test_backpressure();
        dcache_rd_resp_t first;
        bit have_first, to;
        logic ready_at_pop;
        clear_queues();
        have_first = 1'b0;
        first = '0;
        bus.io_resp_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            random_req(1'b1);
            tick();
            if (s_rvalid && !have_first) begin
                first = s_head;
                have_first = 1'b1;
            end else if (have_first) begin
                checks++;
                if (s_head !== first) begin errors++; $display("FAIL bp_stable[%0d] got=%h want %h", i, s_head, first); end
            end
        end
        checks++;
        if (acc_cyc_q.size() != FIFO_DEPTH) begin errors++; $display("FAIL bp_accepted got=%0d want %0d", acc_cyc_q.size(), FIFO_DEPTH); end
        checks++;
        if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got=%b want 0", s_ready); end
        bus.io_req_valid  = 1'b0;
        bus.io_resp_ready = 1'b1;
        tick();
        ready_at_pop = s_ready;
        tick();
        checks++;
        if (ready_at_pop !== 1'b0 || s_ready !== 1'b1)
            begin errors++; $display("FAIL bp_ready_rise got=%b,%b want 0,1", ready_at_pop, s_ready); end
        drain(to);
        checks++;
        if (to || obs_q.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got=%0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_resp[%0d] got=%h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_dual_lane();
        logic [ADDR_W-1:0] a0, a1;
        logic [NWAYS*DATA_W-1:0] row;
        clear_queues();
        a0 = ADDR_W'($urandom);
        a1 = ADDR_W'($urandom);
        row = mem0[a0];
        bus.io_resp_ready = 1'b1;
        drive_req(1'b1, 2'd1, 8'h80, 8'h00, a0, a1, 1'b1, 1'b1);
        tick();
        bus.io_req_valid = 1'b0;
        for (int i = 0; i < 10 && obs_q.size() == 0; i++) tick();
        checks++;
        if (obs_q.size() != 1) begin
            errors++; $display("FAIL dual_count got=%0d want 1", obs_q.size());
        end else begin
            checks++;
            if (obs_q[0].data[0] !== row[7*DATA_W +: DATA_W])
                begin errors++; $display("FAIL dual_data0 got=%h want %h", obs_q[0].data[0], row[7*DATA_W +: DATA_W]); end
            checks++;
            if (obs_q[0].data[1] !== '0 || obs_q[0].valid !== 2'b11 || obs_q[0].tag !== 2'd1)
                begin errors++; $display("FAIL dual_lane1 got data1=%h valid=%b tag=%0d want 0/11/1", obs_q[0].data[1], obs_q[0].valid, obs_q[0].tag); end
        end
    endtask

    task automatic test_reset_midflight();
        bit to;
        clear_queues();
        bus.io_resp_ready = 1'b1;
        random_req(1'b1);
        tick();
        random_req(1'b1);
        tick();
        bus.io_req_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++;
            if (s_ready !== 1'b1 || s_rvalid !== 1'b0)
                begin errors++; $display("FAIL midreset_idle[%0d] got ready=%b valid=%b want 1/0", i, s_ready, s_rvalid); end
        end
        checks++;
        if (obs_q.size() != 0) begin errors++; $display("FAIL midreset_flushed got=%0d responses want 0", obs_q.size()); end
        random_req(1'b1);
        tick();
        drain(to);
        checks++;
        if (to || obs_q.size() != 1 || exp_q.size() != 1)
            begin errors++; $display("FAIL midreset_after_count got=%0d want 1", obs_q.size()); end
        else begin
            checks++;
            if (obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL midreset_after_resp got=%h want %h", obs_q[0], exp_q[0]); end
        end
    endtask

    task automatic test_random();
        bit to;
        clear_queues();
        for (int i = 0; i < 400; i++) begin
            random_req(1'($urandom));
            bus.io_resp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain(to);
        checks++;
        if (to || obs_q.size() != exp_q.size())
            begin errors++; $display("FAIL random_count got=%0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL random_resp[%0d] got=%h want %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        for (int r = 0; r < ROWS; r++) begin
            for (int w = 0; w < NWAYS; w++) begin
                mem0[r][w*DATA_W +: DATA_W] = {$urandom, $urandom};
                mem1[r][w*DATA_W +: DATA_W] = {$urandom, $urandom};
            end
        end
        mem0[12'h123][2*DATA_W +: DATA_W] = 64'hDEADBEEF;
        reset = 1'b1;
        bus.io_resp_ready = 1'b0;
        drive_req(1'b0, '0, '0, '0, '0, '0, 1'b0, 1'b0);
        @(negedge clock);
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_dual_lane();
        test_reset_midflight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
